// File: rtl/d3s_pkg.sv
// Shared constants and helpers for the D3S Frev timestamp path.
// The lane geometry and the ns units are common to the encoder
// and to the receiver-side timestamp logic.
package d3s_pkg;

    localparam int c_phase_bits   = 14;
    localparam int c_lanes        = 4;
    localparam int c_ns_per_cycle = 8;
    localparam int c_ns_per_lane  = 2;
    localparam int c_ns_per_sec   = 1000000000;

    localparam int c_word_bits = c_phase_bits * c_lanes;

    typedef logic [c_phase_bits-1:0] phase_t;
    typedef logic [c_lanes-1:0]      lane_mask_t;
    typedef logic [1:0]              lane_idx_t;

    // Lowest wrapping lane of a word; hit is low when no lane wrapped.
    typedef struct packed {
        logic      hit;
        lane_idx_t lane;
    } lane_sel_t;

    // Per-lane wrap flags: a lane wraps when the previous sample had
    // its MSB set and the current one has it clear (2*pi -> 0).
    // Lane 0 compares against lane 3 of the previous valid word.
    function automatic lane_mask_t wrap_flags(input logic [c_word_bits-1:0] word,
                                              input phase_t                 prev_l3);
        lane_mask_t flags;
        logic       prev_msb;
        logic       cur_msb;
        flags = '0;
        for (int k = 0; k < c_lanes; k++) begin
            cur_msb = word[c_phase_bits*k + c_phase_bits - 1];
            if (k == 0) begin
                prev_msb = prev_l3[c_phase_bits-1];
            end else begin
                prev_msb = word[c_phase_bits*(k-1) + c_phase_bits - 1];
            end
            flags[k] = prev_msb & ~cur_msb;
        end
        return flags;
    endfunction

    // Priority encoder: the earliest (lowest) lane wins.
    function automatic lane_sel_t first_lane(input lane_mask_t flags);
        lane_sel_t sel;
        sel.hit  = 1'b0;
        sel.lane = 2'd0;
        for (int k = c_lanes - 1; k >= 0; k--) begin
            if (flags[k]) begin
                sel.hit  = 1'b1;
                sel.lane = lane_idx_t'(k);
            end else begin
                sel.hit  = sel.hit;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/d3s_ts_adjust.sv
// Combinational TAI/ns subtract with borrow.
// Removes a fixed offset from a (tai, nsec) pair; when nsec is smaller
// than the offset the borrow is taken from the seconds field.
module d3s_ts_adjust
    import d3s_pkg::*;
#(
    parameter logic [31:0] g_adjust_ns = 32'd5000
) (
    input  logic [31:0] tai_i,
    input  logic [31:0] nsec_i,
    output logic [31:0] tai_o,
    output logic [31:0] nsec_o
);

    localparam logic [31:0] c_sec_ns = 32'(c_ns_per_sec);

    // Subtract the offset, borrowing one second when nsec would go negative.
    always_comb begin
        tai_o  = tai_i;
        nsec_o = nsec_i;
        if (nsec_i >= g_adjust_ns) begin
            tai_o  = tai_i;
            nsec_o = nsec_i - g_adjust_ns;
        end else begin
            tai_o  = tai_i - 32'd1;
            nsec_o = nsec_i + c_sec_ns - g_adjust_ns;
        end
    end

endmodule

// File: rtl/d3s_frev_ts_encoder.sv
// Frev timestamp encoder.
// Detects phase wraps in the 4-lane divided phase stream and turns the
// earliest wrapping lane into a WR TAI/ns timestamp, pre-compensated by
// the fixed offset the receiver adds back. Pipeline:
//   stage 1 - register inputs and per-lane wrap flags
//   stage 2 - pick lane, apply holdoff and ratio, form raw ns
//   stage 3 - adjust (registered), then load the output handshake
module d3s_frev_ts_encoder
    import d3s_pkg::*;
#(
    parameter int unsigned g_adjust_ns      = 5000,
    parameter int unsigned g_holdoff_cycles = 4,
    parameter int unsigned g_div_ratio      = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [c_word_bits-1:0] phase_i,
    input  logic                   phase_valid_i,
    input  logic                   tm_time_valid_i,
    input  logic [31:0]            tm_tai_i,
    input  logic [27:0]            tm_cycles_i,
    output logic [31:0]            frev_ts_tai_o,
    output logic [31:0]            frev_ts_nsec_o,
    output logic                   frev_ts_valid_o,
    input  logic                   frev_ts_ready_i,
    output logic                   overflow_o
);

    localparam logic [15:0] c_holdoff   = 16'(g_holdoff_cycles);
    localparam logic [7:0]  c_ratio_max = 8'(g_div_ratio - 1);

    // ---------------- stage 1 ----------------
    phase_t     prev_l3_r;
    lane_mask_t wrap_s;
    lane_mask_t wrap_r;
    logic       pv_r;
    logic       tv_r;
    logic       en_r;
    logic [31:0] tai1_r;
    logic [27:0] cyc1_r;

    // Only the lane MSBs and lane 3 feed the detector; the remaining
    // phase bits are intentionally not needed.
    logic phase_unused_s;
    assign phase_unused_s = ^phase_i;

    // Wrap flags of the incoming word against the last valid lane 3.
    always_comb begin
        wrap_s = wrap_flags(phase_i, prev_l3_r);
    end

    // Stage-1 register: word qualifiers, WR time and wrap flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrap_r <= '0;
            pv_r   <= 1'b0;
            tv_r   <= 1'b0;
            en_r   <= 1'b0;
            tai1_r <= 32'd0;
            cyc1_r <= 28'd0;
        end else begin
            wrap_r <= wrap_s;
            pv_r   <= phase_valid_i;
            tv_r   <= tm_time_valid_i;
            en_r   <= enable_i;
            tai1_r <= tm_tai_i;
            cyc1_r <= tm_cycles_i;
        end
    end

    // Lane 3 history, advanced only by valid words.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_l3_r <= '0;
        end else if (phase_valid_i) begin
            prev_l3_r <= phase_i[c_phase_bits*(c_lanes-1) +: c_phase_bits];
        end else begin
            prev_l3_r <= prev_l3_r;
        end
    end

    // ---------------- stage 2 ----------------
    lane_sel_t   sel_s;
    logic        accept_s;
    logic        emit_s;
    logic [31:0] raw_ns_s;
    logic [15:0] holdoff_r;
    logic [7:0]  ratio_r;
    logic        emit2_r;
    logic [31:0] tai2_r;
    logic [31:0] raw2_r;

    // Lane select, acceptance gating and raw ns of the wrap.
    always_comb begin
        sel_s    = first_lane(wrap_r);
        accept_s = sel_s.hit & en_r & pv_r & tv_r & (holdoff_r == 16'd0);
        emit_s   = accept_s & (ratio_r == 8'd0);
        raw_ns_s = (32'(cyc1_r) * 32'(c_ns_per_cycle))
                 + (32'(sel_s.lane) * 32'(c_ns_per_lane));
    end

    // Holdoff counter: reload on accept, otherwise count down to zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            holdoff_r <= 16'd0;
        end else if (accept_s) begin
            holdoff_r <= c_holdoff;
        end else if (holdoff_r != 16'd0) begin
            holdoff_r <= holdoff_r - 16'd1;
        end else begin
            holdoff_r <= holdoff_r;
        end
    end

    // Ratio counter: modulo count of accepted wraps, cleared while disabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ratio_r <= 8'd0;
        end else if (!en_r) begin
            ratio_r <= 8'd0;
        end else if (accept_s) begin
            if (ratio_r >= c_ratio_max) begin
                ratio_r <= 8'd0;
            end else begin
                ratio_r <= ratio_r + 8'd1;
            end
        end else begin
            ratio_r <= ratio_r;
        end
    end

    // Stage-2 register: emit strobe with its raw timestamp.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            emit2_r <= 1'b0;
            tai2_r  <= 32'd0;
            raw2_r  <= 32'd0;
        end else begin
            emit2_r <= emit_s;
            tai2_r  <= tai1_r;
            raw2_r  <= raw_ns_s;
        end
    end

    // ---------------- stage 3 ----------------
    logic [31:0] adj_tai_s;
    logic [31:0] adj_ns_s;
    logic        emit3_r;
    logic [31:0] tai3_r;
    logic [31:0] ns3_r;

    d3s_ts_adjust #(
        .g_adjust_ns (32'(g_adjust_ns))
    ) u_adjust (
        .tai_i  (tai2_r),
        .nsec_i (raw2_r),
        .tai_o  (adj_tai_s),
        .nsec_o (adj_ns_s)
    );

    // Stage-3 register: adjusted timestamp ready for the output stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            emit3_r <= 1'b0;
            tai3_r  <= 32'd0;
            ns3_r   <= 32'd0;
        end else begin
            emit3_r <= emit2_r;
            tai3_r  <= adj_tai_s;
            ns3_r   <= adj_ns_s;
        end
    end

    // Output handshake: load on emit when the slot is free or being
    // accepted this cycle; an emit against a stalled slot is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frev_ts_tai_o   <= 32'd0;
            frev_ts_nsec_o  <= 32'd0;
            frev_ts_valid_o <= 1'b0;
            overflow_o      <= 1'b0;
        end else if (emit3_r) begin
            if (!frev_ts_valid_o || frev_ts_ready_i) begin
                frev_ts_tai_o   <= tai3_r;
                frev_ts_nsec_o  <= ns3_r;
                frev_ts_valid_o <= 1'b1;
                overflow_o      <= 1'b0;
            end else begin
                frev_ts_tai_o   <= frev_ts_tai_o;
                frev_ts_nsec_o  <= frev_ts_nsec_o;
                frev_ts_valid_o <= 1'b1;
                overflow_o      <= 1'b1;
            end
        end else begin
            frev_ts_tai_o   <= frev_ts_tai_o;
            frev_ts_nsec_o  <= frev_ts_nsec_o;
            frev_ts_valid_o <= frev_ts_valid_o & ~frev_ts_ready_i;
            overflow_o      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_d3s_frev_ts_encoder.sv
// Directed self-checking bench for d3s_frev_ts_encoder.
module tb_d3s_frev_ts_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [55:0] phase;
    logic        phase_valid;
    logic        tm_time_valid;
    logic [31:0] tm_tai;
    logic [27:0] tm_cycles;
    logic        ready;

    logic [31:0] ts_tai,  ts_nsec;
    logic        ts_valid, ovf;
    logic [31:0] ts3_tai, ts3_nsec;
    logic        ts3_valid, ovf3;

    int n_assert = 0;
    int n_fail   = 0;

    logic [55:0] w1;

    always #4 clk = ~clk;

    d3s_frev_ts_encoder dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .phase_i         (phase),
        .phase_valid_i   (phase_valid),
        .tm_time_valid_i (tm_time_valid),
        .tm_tai_i        (tm_tai),
        .tm_cycles_i     (tm_cycles),
        .frev_ts_tai_o   (ts_tai),
        .frev_ts_nsec_o  (ts_nsec),
        .frev_ts_valid_o (ts_valid),
        .frev_ts_ready_i (ready),
        .overflow_o      (ovf)
    );

    d3s_frev_ts_encoder #(.g_div_ratio(3)) dut3 (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .phase_i         (phase),
        .phase_valid_i   (phase_valid),
        .tm_time_valid_i (tm_time_valid),
        .tm_tai_i        (tm_tai),
        .tm_cycles_i     (tm_cycles),
        .frev_ts_tai_o   (ts3_tai),
        .frev_ts_nsec_o  (ts3_nsec),
        .frev_ts_valid_o (ts3_valid),
        .frev_ts_ready_i (ready),
        .overflow_o      (ovf3)
    );

    function automatic logic [55:0] pack(input int l0, input int l1, input int l2, input int l3);
        return {14'(l3), 14'(l2), 14'(l1), 14'(l0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One valid word sampled at the next edge, then the bus goes idle.
    task automatic drive(input logic [55:0] ph, input logic [27:0] cyc);
        phase       = ph;
        tm_cycles   = cyc;
        phase_valid = 1'b1;
        tick(1);
        phase_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; phase = '0; phase_valid = 1'b0;
        tm_time_valid = 1'b1; tm_tai = 32'd7; tm_cycles = 28'd0; ready = 1'b1;
        w1 = pack(16000, 100, 16000, 16000);

        // reset state
        tick(3);
        chk("rst_valid", {31'd0, ts_valid}, 32'd0);
        chk("rst_tai", ts_tai, 32'd0);
        chk("rst_nsec", ts_nsec, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        tick(2);

        // lane 2 wraps: 1000*8 + 4 - 5000 = 3004
        drive(pack(15000, 15000, 15000, 15000), 28'd0);
        tick(6);
        drive(pack(16000, 16300, 100, 400), 28'd1000);
        tick(2);
        chk("t1_not_early", {31'd0, ts_valid}, 32'd0);
        tick(1);
        chk("t1_valid", {31'd0, ts_valid}, 32'd1);
        chk("t1_tai", ts_tai, 32'd7);
        chk("t1_nsec", ts_nsec, 32'd3004);
        tick(8);

        // lane 0 wraps against prev lane 3, borrow: 80 + 1e9 - 5000
        drive(pack(16380, 16380, 16380, 16380), 28'd0);
        tick(6);
        drive(pack(20, 20, 20, 20), 28'd10);
        tick(3);
        chk("t2_valid", {31'd0, ts_valid}, 32'd1);
        chk("t2_tai", ts_tai, 32'd6);
        chk("t2_nsec", ts_nsec, 32'd999995080);
        tick(8);

        // holdoff: wraps at +0 (accepted), +2 (suppressed), +5 (accepted)
        drive(w1, 28'd2000);
        tick(1);
        drive(w1, 28'd2500);
        chk("ho_pre", {31'd0, ts_valid}, 32'd0);
        tick(1);
        chk("ho_first_valid", {31'd0, ts_valid}, 32'd1);
        chk("ho_first_nsec", ts_nsec, 32'd11002);
        tick(1);
        chk("ho_consumed", {31'd0, ts_valid}, 32'd0);
        drive(w1, 28'd3000);
        chk("ho_suppressed", {31'd0, ts_valid}, 32'd0);
        tick(2);
        chk("ho_gap", {31'd0, ts_valid}, 32'd0);
        tick(1);
        chk("ho_second_valid", {31'd0, ts_valid}, 32'd1);
        chk("ho_second_nsec", ts_nsec, 32'd19002);
        tick(8);

        // ratio 3: wraps 0, 3, 6 emit
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        for (int i = 0; i < 7; i++) begin
            drive(w1, 28'(1000 + 100 * i));
            tick(3);
            chk("ratio1_valid", {31'd0, ts_valid}, 32'd1);
            chk("ratio3_valid", {31'd0, ts3_valid}, (i % 3 == 0) ? 32'd1 : 32'd0);
            if (i % 3 == 0) begin
                chk("ratio3_nsec", ts3_nsec, 32'(3002 + 800 * i));
            end
            tick(7);
        end

        // overflow: stalled consumer, second event dropped
        ready = 1'b0;
        drive(w1, 28'd5000);
        tick(3);
        chk("ovf_a_valid", {31'd0, ts_valid}, 32'd1);
        chk("ovf_a_nsec", ts_nsec, 32'd35002);
        chk("ovf_a_ovf", {31'd0, ovf}, 32'd0);
        tick(7);
        drive(w1, 28'd6000);
        tick(2);
        chk("ovf_pre", {31'd0, ovf}, 32'd0);
        tick(1);
        chk("ovf_pulse", {31'd0, ovf}, 32'd1);
        chk("ovf_hold_valid", {31'd0, ts_valid}, 32'd1);
        chk("ovf_hold_nsec", ts_nsec, 32'd35002);
        tick(1);
        chk("ovf_once", {31'd0, ovf}, 32'd0);
        chk("ovf_hold_nsec2", ts_nsec, 32'd35002);
        tick(6);

        // accept and new emit in the same cycle
        drive(w1, 28'd7000);
        tick(2);
        ready = 1'b1;
        tick(1);
        chk("swap_valid", {31'd0, ts_valid}, 32'd1);
        chk("swap_nsec", ts_nsec, 32'd51002);
        chk("swap_ovf", {31'd0, ovf}, 32'd0);
        tick(1);
        chk("swap_consumed", {31'd0, ts_valid}, 32'd0);
        tick(8);

        // reset while a timestamp is pending
        ready = 1'b0;
        drive(w1, 28'd8000);
        tick(3);
        chk("mid_pending", {31'd0, ts_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_valid", {31'd0, ts_valid}, 32'd0);
        chk("mid_tai", ts_tai, 32'd0);
        chk("mid_nsec", ts_nsec, 32'd0);
        chk("mid_ovf", {31'd0, ovf}, 32'd0);
        tick(2);
        rst = 1'b0;
        ready = 1'b1;
        tick(2);

        // qualifiers: no time valid, then no enable, then a normal wrap
        drive(pack(16000, 16000, 16000, 16000), 28'd0);
        tick(6);
        tm_time_valid = 1'b0;
        drive(w1, 28'd100);
        tm_time_valid = 1'b1;
        tick(3);
        chk("q_no_time", {31'd0, ts_valid}, 32'd0);
        tick(6);
        enable = 1'b0;
        drive(w1, 28'd100);
        enable = 1'b1;
        tick(3);
        chk("q_no_enable", {31'd0, ts_valid}, 32'd0);
        tick(6);
        drive(w1, 28'd1000);
        tick(3);
        chk("q_ctrl_valid", {31'd0, ts_valid}, 32'd1);
        chk("q_ctrl_nsec", ts_nsec, 32'd3002);
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
